// File: rtl/cic_comp_fir_if.sv
// cic_comp_fir_if: AXI-Stream style valid/ready data channel.
interface cic_comp_fir_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    modport master (output tdata, output tvalid, input tready);
    modport slave (input tdata, input tvalid, output tready);
endinterface

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: decimating CIC droop-compensation FIR with one time-shared MAC.
module cic_comp_fir #(
    parameter int                           INP_DW   = 32,
    parameter int                           OUT_DW   = 32,
    parameter int                           COEF_DW  = 18,
    parameter int                           NUM_TAPS = 16,
    parameter int                           DECIM    = 2,
    parameter logic [NUM_TAPS*COEF_DW-1:0]  COEFS    = '0,
    parameter int                           SHIFT    = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    cic_comp_fir_if.slave   s_axis_in,
    cic_comp_fir_if.master  m_axis_out
);
    localparam int PW  = $clog2(NUM_TAPS);
    localparam int PHW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int AW  = INP_DW + COEF_DW + PW;
    localparam int RW  = AW + 1 > OUT_DW ? AW + 1 : OUT_DW;
    localparam int BS  = SHIFT > 0 ? SHIFT - 1 : 0;

    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

    state_t                         state, state_nx;
    logic signed [INP_DW-1:0]       smp [NUM_TAPS];
    logic [PW-1:0]                  wr_ptr, rd_ptr, tap;
    logic [PHW-1:0]                 phase;
    logic signed [AW-1:0]           acc;
    logic signed [INP_DW+COEF_DW-1:0] prod;
    logic signed [RW-1:0]           rnd, r, hi;
    logic signed [OUT_DW-1:0]       sat;
    logic [OUT_DW-1:0]              tdata_q;
    logic                           tvalid_q, xfer, trig;

    assign s_axis_in.tready  = state == IDLE && reset_n;
    assign xfer              = s_axis_in.tvalid && s_axis_in.tready;
    assign trig              = xfer && phase == PHW'(DECIM - 1);
    assign prod              = $signed(COEFS[COEF_DW*tap +: COEF_DW]) * smp[rd_ptr];
    assign m_axis_out.tdata  = tdata_q;
    assign m_axis_out.tvalid = tvalid_q;

    // Round half-up, shift, then clamp anything whose bits above the output MSB are not pure sign.
    always_comb begin
        rnd = RW'(acc) + (RW'(SHIFT > 0) <<< BS);
        r   = rnd >>> SHIFT;
        hi  = r >>> (OUT_DW - 1);
        sat = (!r[RW-1] && |hi) ? {1'b0, {(OUT_DW-1){1'b1}}} :
              (r[RW-1] && !(&hi)) ? {1'b1, {(OUT_DW-1){1'b0}}} : r[OUT_DW-1:0];
    end

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE  ? (trig ? MAC : IDLE) :
                   state == MAC   ? (tap == PW'(NUM_TAPS - 1) ? ROUND : MAC) :
                   state == ROUND ? OUT :
                   (m_axis_out.tready ? IDLE : OUT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TAPS; i++) smp[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tap      <= '0;
            phase    <= '0;
            acc      <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            if (xfer) begin
                smp[wr_ptr] <= $signed(s_axis_in.tdata);
                wr_ptr      <= wr_ptr == PW'(NUM_TAPS - 1) ? '0 : wr_ptr + 1'b1;
                phase       <= phase == PHW'(DECIM - 1) ? '0 : phase + 1'b1;
            end
            // The MAC walks backwards from the sample just written.
            if (trig) begin
                acc    <= '0;
                rd_ptr <= wr_ptr;
                tap    <= '0;
            end
            if (state == MAC) begin
                acc    <= acc + AW'(prod);
                rd_ptr <= rd_ptr == '0 ? PW'(NUM_TAPS - 1) : rd_ptr - 1'b1;
                tap    <= tap + 1'b1;
            end
            if (state == ROUND) begin
                tdata_q  <= sat;
                tvalid_q <= 1'b1;
            end
            if (state == OUT && m_axis_out.tready)
                tvalid_q <= 1'b0;
        end
    end
endmodule
